// File: rtl/nibble_carry_accumulator.sv
// Serial multi-precision adder back end: folds inter-nibble carries into a
// stream of 4-bit adder results and presents the assembled word on a valid/ready port.
module nibble_carry_accumulator #(
    parameter int NIBBLES = 4,
    parameter int CNT_W   = $clog2(NIBBLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_sum,
    input  logic                   in_cout,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_len_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_carry;
    logic [CNT_W-1:0]      r_cnt;
    logic [4*NIBBLES-1:0]  r_asm;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [4*NIBBLES-1:0]  r_out_sum;
    logic                  r_out_cout;
    logic [CNT_W-1:0]      r_out_count;
    logic                  r_out_len_err;

    logic                  w_accept;
    logic                  w_start;
    logic                  w_cin;
    logic [4:0]            w_t;
    logic                  w_new_carry;
    logic [CNT_W-1:0]      w_slot;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_done;
    logic                  w_len_err;
    logic [4*NIBBLES-1:0]  w_asm_base;
    logic [4*NIBBLES-1:0]  w_asm_next;

    // Carry fold and slot placement for the nibble currently offered.
    always_comb begin
        w_accept    = in_valid && r_in_ready;
        // Any word start (explicit or implied by IDLE) drops the old carry and partial word.
        w_start     = (r_state == ST_IDLE) || in_first;
        w_cin       = w_start ? 1'b0 : r_carry;
        w_t         = {1'b0, in_sum} + {4'b0000, w_cin};
        w_new_carry = in_cout | w_t[4];
        w_slot      = w_start ? {CNT_W{1'b0}} : r_cnt;
        w_cnt_next  = w_slot + CNT_W'(1);
        w_done      = in_last || (w_slot == CNT_W'(NIBBLES - 1));
        w_len_err   = !in_last || (w_cnt_next != CNT_W'(NIBBLES));
        w_asm_base  = w_start ? {(4*NIBBLES){1'b0}} : r_asm;
        w_asm_next  = w_asm_base;
        for (int k = 0; k < NIBBLES; k++) begin
            w_asm_next[4*k +: 4] = (w_slot == CNT_W'(k)) ? w_t[3:0] : w_asm_base[4*k +: 4];
        end
    end

    // Control FSM with registered handshake and output holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_carry       <= 1'b0;
            r_cnt         <= {CNT_W{1'b0}};
            r_asm         <= {(4*NIBBLES){1'b0}};
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_sum     <= {(4*NIBBLES){1'b0}};
            r_out_cout    <= 1'b0;
            r_out_count   <= {CNT_W{1'b0}};
            r_out_len_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_carry <= w_new_carry;
                        r_cnt   <= w_cnt_next;
                        r_asm   <= w_asm_next;
                        if (w_done) begin
                            r_state       <= ST_HOLD;
                            r_in_ready    <= 1'b0;
                            r_out_valid   <= 1'b1;
                            r_out_sum     <= w_asm_next;
                            r_out_cout    <= w_new_carry;
                            r_out_count   <= w_cnt_next;
                            r_out_len_err <= w_len_err;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_in_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_sum     = r_out_sum;
    assign out_cout    = r_out_cout;
    assign out_count   = r_out_count;
    assign out_len_err = r_out_len_err;

endmodule

// File: tb/tb_nibble_carry_accumulator.sv
// Scoreboard bench for nibble_carry_accumulator with NIBBLES=4.
module tb_nibble_carry_accumulator;

    localparam int NIB = 4;
    localparam int CW  = $clog2(NIB + 1);

    typedef struct packed {
        logic [4*NIB-1:0] sum;
        logic             cout;
        logic [CW-1:0]    count;
        logic             len_err;
    } word_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_sum;
    logic             in_cout;
    logic             in_first;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [4*NIB-1:0] out_sum;
    logic             out_cout;
    logic [CW-1:0]    out_count;
    logic             out_len_err;

    int    n_cmp;
    int    n_err;
    word_t sb[$];

    nibble_carry_accumulator #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_cout    (in_cout),
        .in_first   (in_first),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_count  (out_count),
        .out_len_err(out_len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one nibble and hold it until the DUT takes it (bounded).
    task automatic send_nibble(input logic [3:0] s, input logic c, input logic f, input logic l);
        int waited = 0;
        in_valid = 1'b1; in_sum = s; in_cout = c; in_first = f; in_last = l;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic collect_word(output word_t obs);
        int waited = 0;
        while (out_valid !== 1'b1 && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        if (out_valid !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL collect_timeout out_valid=%b required 1", out_valid);
        end
        obs = {out_sum, out_cout, out_count, out_len_err};
    endtask

    task automatic pop_word();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sum = 4'h0; in_cout = 1'b0; in_first = 1'b0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_sum, out_cout, out_count, out_len_err, in_ready} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_state got v=%b sum=%h c=%b n=%0d e=%b rdy=%b required all 0",
                     out_valid, out_sum, out_cout, out_count, out_len_err, in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_carry_chain();
        word_t obs, exp;
        sb.push_back('{sum: 16'h0000, cout: 1'b1, count: 3'd4, len_err: 1'b0});
        send_nibble(4'h0, 1'b1, 1'b1, 1'b0);
        send_nibble(4'hF, 1'b0, 1'b0, 1'b0);
        send_nibble(4'hF, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL early_valid out_valid=%b required 0", out_valid);
        end
        send_nibble(4'hF, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL latency out_valid=%b required 1", out_valid);
        end
        collect_word(obs);
        exp = sb.pop_front();
        n_cmp++;
        if (obs !== exp) begin
            n_err++; $display("FAIL carry_chain got %h required %h", obs, exp);
        end
        pop_word();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL carry_pop v=%b rdy=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        word_t obs, exp;
        sb.push_back('{sum: 16'h31A5, cout: 1'b0, count: 3'd4, len_err: 1'b0});
        send_nibble(4'h5, 1'b0, 1'b1, 1'b0);
        send_nibble(4'hA, 1'b1, 1'b0, 1'b0);
        send_nibble(4'h0, 1'b0, 1'b0, 1'b0);
        send_nibble(4'h3, 1'b0, 1'b0, 1'b1);
        collect_word(obs);
        exp = sb.pop_front();
        n_cmp++;
        if (obs !== exp) begin
            n_err++; $display("FAIL basic_31a5 got %h required %h", obs, exp);
        end
        pop_word();
        sb.push_back('{sum: 16'h100E, cout: 1'b0, count: 3'd4, len_err: 1'b0});
        send_nibble(4'hE, 1'b1, 1'b1, 1'b0);
        send_nibble(4'hF, 1'b0, 1'b0, 1'b0);
        send_nibble(4'hF, 1'b1, 1'b0, 1'b0);
        send_nibble(4'h0, 1'b0, 1'b0, 1'b1);
        collect_word(obs);
        exp = sb.pop_front();
        n_cmp++;
        if (obs !== exp) begin
            n_err++; $display("FAIL basic_100e got %h required %h", obs, exp);
        end
        pop_word();
    endtask

    task automatic test_backpressure();
        word_t obs, exp, now;
        sb.push_back('{sum: 16'h4321, cout: 1'b1, count: 3'd4, len_err: 1'b0});
        send_nibble(4'h1, 1'b0, 1'b1, 1'b0);
        send_nibble(4'h2, 1'b0, 1'b0, 1'b0);
        send_nibble(4'h3, 1'b0, 1'b0, 1'b0);
        send_nibble(4'h4, 1'b1, 1'b0, 1'b1);
        collect_word(obs);
        // A nibble offered while the word is held must not be taken.
        in_valid = 1'b1; in_sum = 4'h7; in_cout = 1'b1; in_first = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            now = {out_sum, out_cout, out_count, out_len_err};
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || now !== obs) begin
                n_err++;
                $display("FAIL hold_cycle%0d v=%b rdy=%b word=%h required 1/0/%h",
                         i, out_valid, in_ready, now, obs);
            end
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        exp = sb.pop_front();
        n_cmp++;
        if (obs !== exp) begin
            n_err++; $display("FAIL backpressure_word got %h required %h", obs, exp);
        end
        pop_word();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release v=%b rdy=%b required 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_stray_accept out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_short_words();
        word_t obs, exp;
        sb.push_back('{sum: 16'h0043, cout: 1'b0, count: 3'd2, len_err: 1'b1});
        send_nibble(4'h3, 1'b0, 1'b0, 1'b0);
        send_nibble(4'h4, 1'b0, 1'b0, 1'b1);
        collect_word(obs);
        exp = sb.pop_front();
        n_cmp++;
        if (obs !== exp) begin
            n_err++; $display("FAIL short_word got %h required %h", obs, exp);
        end
        pop_word();
        sb.push_back('{sum: 16'h0009, cout: 1'b1, count: 3'd1, len_err: 1'b1});
        send_nibble(4'h9, 1'b1, 1'b1, 1'b1);
        collect_word(obs);
        exp = sb.pop_front();
        n_cmp++;
        if (obs !== exp) begin
            n_err++; $display("FAIL one_nibble got %h required %h", obs, exp);
        end
        pop_word();
    endtask

    task automatic test_forced_and_restart();
        word_t obs, exp;
        sb.push_back('{sum: 16'h4321, cout: 1'b0, count: 3'd4, len_err: 1'b1});
        send_nibble(4'h1, 1'b0, 1'b1, 1'b0);
        send_nibble(4'h2, 1'b0, 1'b0, 1'b0);
        send_nibble(4'h3, 1'b0, 1'b0, 1'b0);
        send_nibble(4'h4, 1'b0, 1'b0, 1'b0);
        collect_word(obs);
        exp = sb.pop_front();
        n_cmp++;
        if (obs !== exp) begin
            n_err++; $display("FAIL forced_completion got %h required %h", obs, exp);
        end
        pop_word();
        // Restart drops 7,8 and the pending carry from nibble 8.
        sb.push_back('{sum: 16'hCBA9, cout: 1'b0, count: 3'd4, len_err: 1'b0});
        send_nibble(4'h7, 1'b0, 1'b1, 1'b0);
        send_nibble(4'h8, 1'b1, 1'b0, 1'b0);
        send_nibble(4'h9, 1'b0, 1'b1, 1'b0);
        send_nibble(4'hA, 1'b0, 1'b0, 1'b0);
        send_nibble(4'hB, 1'b0, 1'b0, 1'b0);
        send_nibble(4'hC, 1'b0, 1'b0, 1'b1);
        collect_word(obs);
        exp = sb.pop_front();
        n_cmp++;
        if (obs !== exp) begin
            n_err++; $display("FAIL mid_restart got %h required %h", obs, exp);
        end
        pop_word();
    endtask

    task automatic test_reset_mid_word();
        word_t obs, exp;
        send_nibble(4'h5, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, out_sum, out_cout, out_count, out_len_err, in_ready} !== 24'h0) begin
            n_err++; $display("FAIL reset_accum v=%b sum=%h rdy=%b required 0", out_valid, out_sum, in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        send_nibble(4'h1, 1'b0, 1'b1, 1'b0);
        send_nibble(4'h2, 1'b0, 1'b0, 1'b0);
        send_nibble(4'h3, 1'b0, 1'b0, 1'b0);
        send_nibble(4'h4, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, out_sum, out_cout, out_count, out_len_err, in_ready} !== 24'h0) begin
            n_err++; $display("FAIL reset_hold v=%b sum=%h c=%b rdy=%b required 0",
                              out_valid, out_sum, out_cout, in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        sb.push_back('{sum: 16'h0001, cout: 1'b0, count: 3'd1, len_err: 1'b1});
        send_nibble(4'h1, 1'b0, 1'b1, 1'b1);
        collect_word(obs);
        exp = sb.pop_front();
        n_cmp++;
        if (obs !== exp) begin
            n_err++; $display("FAIL post_reset_word got %h required %h", obs, exp);
        end
        pop_word();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_carry_chain();
        test_basic();
        test_backpressure();
        test_short_words();
        test_forced_and_restart();
        test_reset_mid_word();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_leftover entries=%0d required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nibble_carry_accumulator.md
Name: nibble_carry_accumulator

Overview:
- Downstream stage of the 4-bit Kogge-Stone adder. That adder has no carry-in.
- This block consumes the adder's per-nibble result (sum[3:0], carry_out) one nibble per cycle, least-significant nibble first.
- It folds the inter-nibble carry into each result and assembles a NIBBLES*4-bit sum plus a final carry.
- Together with the adder, it forms a serial multi-precision adder. The assembled word goes out through a valid/ready output buffer.

Parameters:
- NIBBLES, 4, number of nibbles per operand (result width = 4*NIBBLES); legal range 2..16.
- CNT_W, $clog2(NIBBLES+1), width of the nibble counter and of out_count.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- in_valid  input  1  nibble result present
- in_ready  output  1  block can accept a nibble this cycle
- in_sum  input  4  adder sum[3:0]
- in_cout  input  1  adder carry_out
- in_first  input  1  nibble is the least-significant nibble of a new word
- in_last  input  1  nibble is the most-significant nibble of the word
- out_valid  output  1  assembled word available
- out_ready  input  1  consumer takes word
- out_sum  output  4*NIBBLES  assembled sum, nibble k at bits [4k+3:4k]
- out_cout  output  1  carry out of the top nibble
- out_count  output  CNT_W  number of nibbles in the word
- out_len_err  output  1  word ended with count != NIBBLES

Behaviour:
- Interface (decided): one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset, applied on any clk edge with rst=1, overrides all other activity, including a half-assembled word or a pending output:
  - state = IDLE
  - carry register = 0, nibble counter = 0, assembly register = 0
  - out_valid = 0, out_sum = 0, out_cout = 0, out_count = 0, out_len_err = 0
  - in_ready = 0 during the reset cycle, 1 the cycle after
- Accept: a nibble is taken when in_valid && in_ready on a rising edge.
- in_ready = 1 in IDLE and ACCUM; 0 in HOLD.
- Carry fold, per accepted nibble:
  - c_in = 0 if in_first or state==IDLE, else the carry register.
  - t[4:0] = in_sum + c_in
  - stored nibble = t[3:0]
  - new carry = in_cout | t[4] (both cannot be 1 together; t[4] only when in_sum==F and c_in==1)
- Placement: the stored nibble goes to slot index = counter (0 when first), and the counter increments. Slots above the last written nibble read 0 in out_sum.
- States:
  - IDLE: any accepted nibble starts a word, whether or not in_first is set (in_first is implied). If in_last → HOLD, else → ACCUM.
  - ACCUM:
    - Accepted nibble with in_first: discard the partial word, restart at slot 0 with c_in=0.
    - Accepted nibble with in_last, or nibble filling slot NIBBLES-1: → HOLD.
  - HOLD:
    - out_valid = 1 starting the cycle after the completing nibble (latency 1).
    - out_sum, out_cout (final carry register), out_count and out_len_err are stable while out_valid && !out_ready.
    - out_ready=1 → IDLE, out_valid=0 next cycle. The output stays registered and there is no same-cycle in→out bypass.
- Length rules:
  - Word completed by in_last with count < NIBBLES: out_len_err = 1, upper slots 0.
  - Slot NIBBLES-1 filled without in_last: force completion, out_len_err = 1.
  - in_first && in_last on one nibble: a one-nibble word, out_len_err = 1 unless NIBBLES==1 (illegal, so always 1).
- Data inputs while in_valid=0 are don't-care; in_first/in_last are sampled only on accept.

Test Plan:
- NIBBLES=4, nibbles (sum,cout) = (0,1),(F,0),(F,0),(F,0) with first on #0 and last on #3 (0xFFFF+0x0001) → out_sum=0x0000, out_cout=1, out_count=4, out_len_err=0, out_valid 1 cycle after the last accept.
- Nibbles (5,0),(A,1),(0,0),(3,0) (0x31A5 plus 0x0F00 style) → out_sum=0x31A5, out_cout=0; then the carry chain (E,1),(F,0),(F,1),(0,0) → out_sum=0x100E, out_cout=0.
- Backpressure: complete a word with out_ready=0 for 5 cycles → in_ready=0 and outputs constant throughout. Pulse out_ready → out_valid drops next cycle, in_ready=1.
- Short word (3,0),(4,0) with last on #1 → out_sum=0x0043, out_count=2, out_len_err=1.
- Four nibbles with no in_last → forced completion, out_len_err=1. Also assert in_first on nibble #2 mid-word → the word restarts and the prior two nibbles are absent from out_sum.
- Assert rst while in ACCUM with carry=1 and again in HOLD → all outputs 0 the next cycle. The next word (1,0) first/last → out_sum=0x0001, showing the carry was cleared.
